// File: rtl/video_timing_pkg.sv
// Shared types, default mode timings and axis bound helper for the video timing generator.
package video_timing_pkg;

    // Run-control states of the generator.
    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUNNING  = 2'd1,
        DRAINING = 2'd2
    } state_t;

    // SVGA 800x600 @ 60 Hz (40 MHz pixel clock).
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;

    // VGA 640x480 @ 60 Hz (25.175 MHz pixel clock).
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Total length of one axis and the half-open sync window [sync_start, sync_end).
    typedef struct packed {
        int total;
        int sync_start;
        int sync_end;
    } axis_bounds_t;

    function automatic axis_bounds_t axis_bounds(int active, int fp, int sync, int bp);
        axis_bounds_t b;
        b.total      = active + fp + sync + bp;
        b.sync_start = active + fp;
        b.sync_end   = active + fp + sync;
        return b;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Run handshake plus timing outputs of the video timing generator.
//
// Handshake: enable is a level run request, not a per-transfer valid. The
// generator reports stopped=1 only while idle; dropping enable lets the current
// frame finish, and stopped rises one edge after that frame's last pixel.
// state is a debug view of the run-control FSM.
interface video_timing_gen_if
    import video_timing_pkg::*;
#(
    parameter int X_W  = 11,
    parameter int Y_W  = 10,
    parameter int FC_W = 16
);
    logic            enable;
    logic            stopped;
    logic            hs;
    logic            vs;
    logic            de;
    logic [X_W-1:0]  pixelX;
    logic [Y_W-1:0]  pixelY;
    logic            lineStart;
    logic            frameStart;
    logic [FC_W-1:0] frameCount;
    state_t          state;

    modport master (
        output enable,
        input  stopped, hs, vs, de, pixelX, pixelY, lineStart, frameStart, frameCount, state
    );

    modport slave (
        input  enable,
        output stopped, hs, vs, de, pixelX, pixelY, lineStart, frameStart, frameCount, state
    );
endinterface

// File: rtl/video_axis_counter.sv
// One timing axis: position counter with wrap, active-region decode and polarised sync decode.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = 800,
    parameter int FP     = 40,
    parameter int SYNC   = 128,
    parameter int BP     = 88,
    parameter bit POL    = 1'b1,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync
);
    localparam axis_bounds_t B = axis_bounds(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST = W'(B.total - 1);

    // Decode on a 32-bit copy so a sync window ending exactly at 2^W still compares correctly.
    logic [31:0] cnt_ext;
    assign cnt_ext = 32'(cnt);

    // Position register: held at zero while cleared, otherwise steps and wraps after LAST.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

    assign wrap   = (cnt == LAST);
    assign active = (cnt_ext < 32'(ACTIVE));
    assign sync   = ((cnt_ext >= 32'(B.sync_start)) && (cnt_ext < 32'(B.sync_end))) ? POL : ~POL;

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: run-control FSM, two axis counters and one registered output stage.
// Counters hold the pixel being decoded; outputs show it one edge later, all aligned.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_FP     = SVGA_H_FP,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BP     = SVGA_H_BP,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_FP     = SVGA_V_FP,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BP     = SVGA_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int X_W      = 11,
    parameter int Y_W      = 10,
    parameter int FC_W     = 16
) (
    input  logic               pixelClk,
    input  logic               reset,
    video_timing_gen_if.slave  vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Reject geometries that cannot be counted or would never produce sync/video.
    if ((H_TOTAL - 1) >= (1 << X_W)) begin : g_bad_x_w
        $error("video_timing_gen: H_TOTAL-1 does not fit in X_W bits");
    end
    if ((V_TOTAL - 1) >= (1 << Y_W)) begin : g_bad_y_w
        $error("video_timing_gen: V_TOTAL-1 does not fit in Y_W bits");
    end
    if (H_SYNC == 0 || V_SYNC == 0 || H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_zero
        $error("video_timing_gen: H_SYNC, V_SYNC, H_ACTIVE and V_ACTIVE must be non-zero");
    end

    state_t         state;
    state_t         state_nxt;
    logic           run;
    logic           cnt_clear;
    logic           v_inc;
    logic           frame_last;
    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;
    logic           h_wrap;
    logic           v_wrap;
    logic           h_act;
    logic           v_act;
    logic           h_sync;
    logic           v_sync;

    assign frame_last = h_wrap && v_wrap;

    // State register; reset always lands in STOPPED regardless of enable.
    always_ff @(posedge pixelClk) begin
        if (reset) begin
            state <= STOPPED;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: draining finishes the frame in flight unless enable returns first.
    always_comb begin
        state_nxt = state;
        case (state)
            STOPPED:  if (vif.enable) state_nxt = RUNNING;
            RUNNING:  if (!vif.enable) state_nxt = DRAINING;
            DRAINING: begin
                if (vif.enable) begin
                    state_nxt = RUNNING;
                end else if (frame_last) begin
                    state_nxt = STOPPED;
                end
            end
            default:  state_nxt = STOPPED;
        endcase
    end

    // FSM outputs: counters advance in both active states and sit at (0,0) while stopped.
    always_comb begin
        run       = (state == RUNNING) || (state == DRAINING);
        cnt_clear = !run;
        v_inc     = run && h_wrap;
    end

    video_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(X_W)
    ) u_h_axis (
        .clk(pixelClk), .rst(reset), .clear(cnt_clear), .inc(run),
        .cnt(h_cnt), .wrap(h_wrap), .active(h_act), .sync(h_sync)
    );

    video_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(Y_W)
    ) u_v_axis (
        .clk(pixelClk), .rst(reset), .clear(cnt_clear), .inc(v_inc),
        .cnt(v_cnt), .wrap(v_wrap), .active(v_act), .sync(v_sync)
    );

    // Output stage: decode of the current counters, or idle levels while not running.
    always_ff @(posedge pixelClk) begin
        if (reset || !run) begin
            vif.stopped    <= 1'b1;
            vif.de         <= 1'b0;
            vif.hs         <= ~HS_POL;
            vif.vs         <= ~VS_POL;
            vif.pixelX     <= '0;
            vif.pixelY     <= '0;
            vif.lineStart  <= 1'b0;
            vif.frameStart <= 1'b0;
            if (reset) begin
                vif.frameCount <= '0;
            end
        end else begin
            vif.stopped    <= 1'b0;
            vif.de         <= h_act && v_act;
            vif.hs         <= h_sync;
            vif.vs         <= v_sync;
            vif.pixelX     <= (h_act && v_act) ? h_cnt : '0;
            vif.pixelY     <= (h_act && v_act) ? v_cnt : '0;
            vif.lineStart  <= (h_cnt == '0);
            vif.frameStart <= (h_cnt == '0) && (v_cnt == '0);
            if ((h_cnt == '0) && (v_cnt == '0)) begin
                vif.frameCount <= vif.frameCount + 1'b1;
            end
        end
    end

    assign vif.state = state;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a tiny 8x6 raster (4/1/2/1 by 3/1/1/1).
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int X_W  = 3;
    localparam int Y_W  = 3;
    localparam int FC_W = 2;
    localparam int HT   = 8;
    localparam int VT   = 6;
    localparam int FRAME = HT * VT;

    logic pixelClk;
    logic reset;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    video_timing_gen_if #(.X_W(X_W), .Y_W(Y_W), .FC_W(FC_W)) vif ();

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1),
        .X_W(X_W), .Y_W(Y_W), .FC_W(FC_W)
    ) dut (
        .pixelClk(pixelClk),
        .reset(reset),
        .vif(vif)
    );

    // Clock: 10 time-unit period.
    initial begin
        pixelClk = 1'b0;
        forever #5 pixelClk = ~pixelClk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; leave 1 time unit so outputs have settled before sampling.
    task automatic tick();
        @(posedge pixelClk);
        #1;
    endtask

    function automatic logic [31:0] observe();
        return {18'd0, vif.stopped, vif.de, vif.hs, vif.vs, vif.lineStart, vif.frameStart,
                vif.frameCount, vif.pixelX, vif.pixelY};
    endfunction

    // Expected outputs while showing pixel (h,v); hs is active-low on h 5..6, vs active-high on v 4.
    function automatic logic [31:0] exp_pixel(int h, int v, int fc);
        logic       de_e;
        logic       hs_e;
        logic       vs_e;
        logic [1:0] fc_e;
        logic [2:0] x_e;
        logic [2:0] y_e;
        de_e = (h < 4) && (v < 3);
        hs_e = !((h == 5) || (h == 6));
        vs_e = (v == 4);
        fc_e = fc[1:0];
        x_e  = de_e ? h[2:0] : 3'd0;
        y_e  = de_e ? v[2:0] : 3'd0;
        return {18'd0, 1'b0, de_e, hs_e, vs_e, (h == 0), (h == 0) && (v == 0), fc_e, x_e, y_e};
    endfunction

    function automatic logic [31:0] exp_idle(int fc);
        logic [1:0] fc_e;
        fc_e = fc[1:0];
        return {18'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, fc_e, 3'd0, 3'd0};
    endfunction

    // Scoreboard step: queue the expectation, then retire it against the sampled outputs.
    task automatic expect_now(input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        check(tag, observe(), exp_q.pop_front());
    endtask

    // Walk one full frame; enable may be toggled at given cycle indices (-1 = never).
    task automatic run_frame(input string name, input int fc, input int drop_at, input int raise_at);
        for (int i = 0; i < FRAME; i++) begin
            expect_now($sformatf("%s_h%0d_v%0d", name, i % HT, i / HT), exp_pixel(i % HT, i / HT, fc));
            if (i == drop_at) vif.enable = 1'b0;
            if (i == raise_at) vif.enable = 1'b1;
            tick();
        end
    endtask

    task automatic idle_cycles(input string name, input int n, input int fc);
        for (int i = 0; i < n; i++) begin
            expect_now($sformatf("%s_%0d", name, i), exp_idle(fc));
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        vif.enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        expect_now("reset_idle", exp_idle(0));
        check("reset_state", 32'(vif.state), 32'(STOPPED));
        idle_cycles("stopped_hold", 3, 0);

        // Start: enable sampled at edge k, first pixel shown after edge k+1.
        vif.enable = 1'b1;
        tick();
        expect_now("start_gap", exp_idle(0));
        tick();
        check("run_state", 32'(vif.state), 32'(RUNNING));

        // Free run over four frames: frameCount 1,2,3,0.
        for (int f = 0; f < 4; f++) begin
            run_frame($sformatf("free%0d", f), (f + 1) % 4, -1, -1);
        end

        // Drain: enable drops while pixel (2,1) is shown; the frame still completes.
        run_frame("drain", 1, 10, -1);
        check("drain_done_state", 32'(vif.state), 32'(STOPPED));
        idle_cycles("after_drain", 20, 1);

        // Restart, then a short enable dropout from (0,2) to (3,4) leaves no gap.
        vif.enable = 1'b1;
        tick();
        expect_now("restart_gap", exp_idle(1));
        tick();
        run_frame("dropout", 2, 16, 35);
        run_frame("post_dropout", 3, -1, -1);

        // Mid-frame reset at (1,1) with enable held high.
        for (int i = 0; i < 9; i++) begin
            expect_now($sformatf("pre_reset_%0d", i), exp_pixel(i % HT, i / HT, 0));
            tick();
        end
        expect_now("pre_reset_h1_v1", exp_pixel(1, 1, 0));
        reset = 1'b1;
        tick();
        expect_now("reset_mid_frame", exp_idle(0));
        tick();
        expect_now("reset_held_enable", exp_idle(0));
        reset = 1'b0;
        tick();
        expect_now("release_gap", exp_idle(0));
        tick();
        run_frame("after_reset", 1, -1, -1);
        run_frame("after_reset2", 2, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
